// File: rtl/alu_param.sv
// alu_param: parametrised multi-cycle signed ALU (logic, add/sub, Booth MUL, DIV).
// Define ALU_DIV_EN to build the restoring divider; otherwise op 110 is reserved.
module alu_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    input  logic [2:0]         op,
    input  logic               begin_signal,
    output logic               busy,
    output logic               end_signal,
    output logic [2*WIDTH-1:0] OUT,
    output logic               ovf,
    output logic               dz,
    output logic               illegal
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
`ifdef ALU_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b110;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]   xr, yr;
    logic [2:0]         opr;
    logic [WIDTH:0]     a, m;
    logic [WIDTH-1:0]   q;
    logic               q1;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] res;
    logic               res_ovf, res_dz, res_ill;

    logic               div_op, long_op, last;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH:0]     booth_sum;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   xmag, ymag;
    logic [WIDTH:0]     a_shl, trial;

    assign div_op = (opr == OP_DIV);
    assign xmag   = xr[WIDTH-1] ? -xr : xr;
    assign ymag   = yr[WIDTH-1] ? -yr : yr;
    assign a_shl  = {a[WIDTH-1:0], q[WIDTH-1]};
    assign trial  = a_shl - m;
`else
    assign div_op = 1'b0;
`endif

    assign long_op = (opr == OP_MUL) || (div_op && (yr != '0));
    assign last    = (cnt == LAST);
    assign sum     = xr + yr;
    assign diff    = xr - yr;

    // Booth add/subtract of the multiplicand selected by {Q0, Q-1}
    always_comb begin
        booth_sum = a;
        case ({q[0], q1})
            2'b01:   booth_sum = a + m;
            2'b10:   booth_sum = a - m;
            default: booth_sum = a;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (begin_signal) state_n = LOAD;
            LOAD:    state_n = long_op ? CALC : DONE;
            CALC:    if (last) state_n = div_op ? FIXUP : DONE;
            FIXUP:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture and arithmetic datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr      <= '0;
            yr      <= '0;
            opr     <= '0;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q1      <= 1'b0;
            cnt     <= '0;
            res     <= '0;
            res_ovf <= 1'b0;
            res_dz  <= 1'b0;
            res_ill <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (begin_signal) begin
                        xr  <= X;
                        yr  <= Y;
                        opr <= op;
                    end
                end
                LOAD: begin
                    cnt     <= '0;
                    q1      <= 1'b0;
                    a       <= '0;
                    res     <= '0;
                    res_ovf <= 1'b0;
                    res_dz  <= 1'b0;
                    res_ill <= 1'b0;
                    case (opr)
                        OP_AND: res <= {{WIDTH{1'b0}}, xr & yr};
                        OP_OR:  res <= {{WIDTH{1'b0}}, xr | yr};
                        OP_XOR: res <= {{WIDTH{1'b0}}, xr ^ yr};
                        OP_ADD: begin
                            res     <= {{WIDTH{1'b0}}, sum};
                            res_ovf <= (xr[WIDTH-1] == yr[WIDTH-1]) &&
                                       (sum[WIDTH-1] != xr[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res     <= {{WIDTH{1'b0}}, diff};
                            res_ovf <= (xr[WIDTH-1] != yr[WIDTH-1]) &&
                                       (diff[WIDTH-1] != xr[WIDTH-1]);
                        end
                        OP_MUL: begin
                            q <= yr;
                            m <= {xr[WIDTH-1], xr};
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (yr == '0) begin
                                res    <= {xr, {WIDTH{1'b1}}};
                                res_dz <= 1'b1;
                            end else begin
                                q <= xmag;
                                m <= {1'b0, ymag};
                            end
                        end
`endif
                        default: res_ill <= 1'b1;
                    endcase
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
`ifdef ALU_DIV_EN
                    if (div_op) begin
                        if (trial[WIDTH]) begin
                            a <= a_shl;
                            q <= {q[WIDTH-2:0], 1'b0};
                        end else begin
                            a <= trial;
                            q <= {q[WIDTH-2:0], 1'b1};
                        end
                    end else
`endif
                    begin
                        a  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q  <= {booth_sum[0], q[WIDTH-1:1]};
                        q1 <= q[0];
                        if (last) res <= {booth_sum, q[WIDTH-1:1]};
                    end
                end
                FIXUP: begin
`ifdef ALU_DIV_EN
                    res[2*WIDTH-1:WIDTH] <= xr[WIDTH-1] ? -a[WIDTH-1:0]
                                                        : a[WIDTH-1:0];
                    res[WIDTH-1:0] <= (xr[WIDTH-1] ^ yr[WIDTH-1]) ? -q : q;
                    res_ovf <= (xr == {1'b1, {(WIDTH-1){1'b0}}}) &&
                               (yr == {WIDTH{1'b1}});
`endif
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    // Registered handshake, result and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            end_signal <= 1'b0;
            OUT        <= '0;
            ovf        <= 1'b0;
            dz         <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            end_signal <= (state == DONE);
            busy       <= (state != IDLE) || (state_n != IDLE);
            if (state == IDLE && begin_signal) begin
                ovf     <= 1'b0;
                dz      <= 1'b0;
                illegal <= 1'b0;
            end
            if (state == DONE) begin
                OUT     <= res;
                ovf     <= res_ovf;
                dz      <= res_dz;
                illegal <= res_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_param.sv
// tb_alu_param: directed self-checking bench for alu_param at WIDTH=8.
// DIV expectations follow ALU_DIV_EN; without it op 110 must report illegal.
module tb_alu_param;

    logic        clk;
    logic        reset;
    logic [7:0]  X, Y;
    logic [2:0]  op;
    logic        begin_signal;
    logic        busy, end_signal;
    logic [15:0] OUT;
    logic        ovf, dz, illegal;

    int checks = 0;
    int errors = 0;

    alu_param #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .X(X),
        .Y(Y),
        .op(op),
        .begin_signal(begin_signal),
        .busy(busy),
        .end_signal(end_signal),
        .OUT(OUT),
        .ovf(ovf),
        .dz(dz),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, optionally pulse
    // begin_signal at edge 'pulse', then check latency and results.
    task automatic run_op(input string tag, input logic [7:0] x,
                          input logic [7:0] y, input logic [2:0] o,
                          input int lat, input logic [15:0] out_e,
                          input logic ovf_e, input logic dz_e,
                          input logic ill_e, input int pulse);
        int n;
        @(negedge clk);
        X = x;
        Y = y;
        op = o;
        begin_signal = 1'b1;
        @(posedge clk);
        #1;
        begin_signal = 1'b0;
        X = ~x;
        Y = ~y;
        op = 3'b011;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!end_signal && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            begin_signal = (n == pulse);
        end
        begin_signal = 1'b0;
        check({tag, "_lat"}, n, lat);
        check({tag, "_out"}, {16'd0, OUT}, {16'd0, out_e});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ovf_e});
        check({tag, "_dz"}, {31'd0, dz}, {31'd0, dz_e});
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, ill_e});
        @(posedge clk);
        #1;
        check({tag, "_endlow"}, {31'd0, end_signal}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, {16'd0, OUT}, {16'd0, out_e});
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        X = '0;
        Y = '0;
        op = '0;
        begin_signal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_end", {31'd0, end_signal}, 32'd0);
        check("rst_out", {16'd0, OUT}, 32'd0);
        check("rst_flags", {29'd0, ovf, dz, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("xor", 8'hA5, 8'h0F, 3'b010, 2, 16'h00AA, 0, 0, 0, -1);
        run_op("and", 8'hF0, 8'h3C, 3'b000, 2, 16'h0030, 0, 0, 0, -1);
        run_op("or",  8'h50, 8'h0A, 3'b001, 2, 16'h005A, 0, 0, 0, -1);
        run_op("add_ovf", 8'h7F, 8'h01, 3'b011, 2, 16'h0080, 1, 0, 0, -1);
        run_op("add", 8'hFE, 8'h03, 3'b011, 2, 16'h0001, 0, 0, 0, -1);
        run_op("sub_ovf", 8'h80, 8'h01, 3'b100, 2, 16'h007F, 1, 0, 0, -1);
        run_op("sub", 8'h05, 8'h07, 3'b100, 2, 16'h00FE, 0, 0, 0, -1);
        run_op("mul_pulse", 8'hFD, 8'h07, 3'b101, 10, 16'hFFEB, 0, 0, 0, 4);
        run_op("mul_min", 8'h80, 8'h80, 3'b101, 10, 16'h4000, 0, 0, 0, -1);
        run_op("mul_neg", 8'h7F, 8'hFF, 3'b101, 10, 16'hFF81, 0, 0, 0, -1);
        run_op("rsv", 8'h12, 8'h34, 3'b111, 2, 16'h0000, 0, 0, 1, -1);
`ifdef ALU_DIV_EN
        run_op("div_neg", 8'hF9, 8'h02, 3'b110, 11, 16'hFFFD, 0, 0, 0, -1);
        run_op("div_min", 8'h80, 8'hFF, 3'b110, 11, 16'h0080, 1, 0, 0, -1);
        run_op("div_pos", 8'h64, 8'h07, 3'b110, 11, 16'h020E, 0, 0, 0, -1);
        run_op("div_mix", 8'h07, 8'hFE, 3'b110, 11, 16'h01FD, 0, 0, 0, -1);
        run_op("div_zero", 8'h25, 8'h00, 3'b110, 2, 16'h25FF, 0, 1, 0, -1);
`else
        run_op("div_off", 8'h10, 8'h02, 3'b110, 2, 16'h0000, 0, 0, 1, -1);
        run_op("div0_off", 8'h25, 8'h00, 3'b110, 2, 16'h0000, 0, 0, 1, -1);
`endif
        run_op("mul_pre", 8'h03, 8'h05, 3'b101, 10, 16'h000F, 0, 0, 0, -1);

        @(negedge clk);
        X = 8'h12;
        Y = 8'h34;
        op = 3'b101;
        begin_signal = 1'b1;
        @(posedge clk);
        #1;
        begin_signal = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out", {16'd0, OUT}, 32'd0);
        check("abort_flags", {29'd0, ovf, dz, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (end_signal || busy) seen = 1;
        end
        check("abort_noend", seen, 0);

        run_op("post_rst", 8'h05, 8'h03, 3'b011, 2, 16'h0008, 0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
